// File: rtl/oled_spi_sink.sv
// Responder for the 4-wire OLED serial link: synchronizes the link, assembles bytes,
// decodes an SSD1306 command subset and emits frame-buffer writes. Define OLED_SINK_FB_EN for the internal RAM.
module oled_spi_sink #(
  parameter int COLS        = 128,
  parameter int PAGES       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       oled_csn,
  input  logic       oled_rst,
  input  logic       oled_dcn,
  input  logic       oled_clk,
  input  logic       oled_dat,
  output logic       fb_we,
  output logic [8:0] fb_addr,
  output logic [7:0] fb_wdata,
  output logic       cmd_strobe,
  output logic [7:0] cmd_byte,
  output logic       disp_on,
  output logic [7:0] contrast,
  output logic [1:0] addr_mode,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int CW = $clog2(COLS);
  localparam int PW = $clog2(PAGES);

  typedef enum logic [1:0] {IDLE, ARG1, ARG2} state_t;
  typedef enum logic [2:0] {T_NONE, T_CONTRAST, T_MODE, T_COL, T_PAGE} tgt_t;
  typedef enum logic [3:0] {
    A_NONE, A_DISP_OFF, A_DISP_ON, A_CONTRAST, A_MODE, A_COL_START, A_COL_END,
    A_PAGE_START, A_PAGE_END, A_PAGE, A_COL_LO, A_COL_HI, A_DATA
  } act_t;

  logic [SYNC_STAGES-1:0] csn_sync, prst_sync, clk_sync, dcn_sync, dat_sync;
  logic                   clk_q;
  logic                   csn_s, prst_s, clk_s, dcn_s, dat_s;
  logic [6:0]             shreg;
  logic [2:0]             bit_cnt;
  logic                   hold;
  logic                   rise_p0, vld_p0, dc_p0, cmd_vld_p0, dat_vld_p0;
  logic [7:0]             byte_p0;
  state_t                 state, state_nxt;
  tgt_t                   tgt, tgt_nxt;
  act_t                   act;
  logic [CW-1:0]          col, col_start, col_end;
  logic [PW-1:0]          page, page_start, page_end;

  function automatic logic [CW-1:0] col_inc(input logic [CW-1:0] c);
    return (c == CW'(COLS - 1)) ? '0 : c + 1'b1;
  endfunction

  function automatic logic [PW-1:0] page_inc(input logic [PW-1:0] p);
    return (p == PW'(PAGES - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [8:0] addr_of(input logic [PW-1:0] p, input logic [CW-1:0] c);
    return 9'(int'(p) * COLS + int'(c));
  endfunction

  // Input synchronizers and sclk edge detect
  always_ff @(posedge clk) begin
    if (rst) begin
      csn_sync  <= '1;
      prst_sync <= '1;
      clk_sync  <= '0;
      clk_q     <= 1'b0;
    end else begin
      csn_sync  <= {csn_sync[SYNC_STAGES-2:0], oled_csn};
      prst_sync <= {prst_sync[SYNC_STAGES-2:0], oled_rst};
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], oled_clk};
      clk_q     <= clk_s;
    end
  end

  always_ff @(posedge clk) begin
    dcn_sync <= {dcn_sync[SYNC_STAGES-2:0], oled_dcn};
    dat_sync <= {dat_sync[SYNC_STAGES-2:0], oled_dat};
  end

  assign csn_s  = csn_sync[SYNC_STAGES-1];
  assign prst_s = prst_sync[SYNC_STAGES-1];
  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign dcn_s  = dcn_sync[SYNC_STAGES-1];
  assign dat_s  = dat_sync[SYNC_STAGES-1];
  assign hold   = rst | ~prst_s;

  // p0: edge cycle E, byte completes on the eighth rise
  assign rise_p0    = clk_s & ~clk_q & ~csn_s;
  assign byte_p0    = {shreg, dat_s};
  assign dc_p0      = dcn_s;
  assign vld_p0     = rise_p0 & (bit_cnt == 3'd7) & ~hold;
  assign cmd_vld_p0 = vld_p0 & ~dc_p0;
  assign dat_vld_p0 = vld_p0 & dc_p0;

  always_ff @(posedge clk) begin
    if (hold || csn_s) bit_cnt <= '0;
    else if (rise_p0)  bit_cnt <= bit_cnt + 3'd1;
  end

  always_ff @(posedge clk) begin
    if (rise_p0) shreg <= byte_p0[6:0];
  end

  always_ff @(posedge clk) begin
    if (hold) begin
      state <= IDLE;
      tgt   <= T_NONE;
    end else begin
      state <= state_nxt;
      tgt   <= tgt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tgt_nxt   = tgt;
    if (dat_vld_p0) begin
      state_nxt = IDLE;
    end else if (cmd_vld_p0) begin
      case (state)
        IDLE: begin
          tgt_nxt = T_NONE;
          case (byte_p0)
            8'h81: begin state_nxt = ARG1; tgt_nxt = T_CONTRAST; end
            8'h20: begin state_nxt = ARG1; tgt_nxt = T_MODE; end
            8'h21: begin state_nxt = ARG1; tgt_nxt = T_COL; end
            8'h22: begin state_nxt = ARG1; tgt_nxt = T_PAGE; end
            8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB, 8'h8D: state_nxt = ARG1;
            default: ;
          endcase
        end
        ARG1:    state_nxt = (tgt == T_COL || tgt == T_PAGE) ? ARG2 : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    act = A_NONE;
    if (dat_vld_p0) begin
      act = A_DATA;
    end else if (cmd_vld_p0) begin
      case (state)
        IDLE: begin
          case (byte_p0) inside
            8'hAE:           act = A_DISP_OFF;
            8'hAF:           act = A_DISP_ON;
            [8'hB0:8'hB3]:   act = A_PAGE;
            [8'h00:8'h0F]:   act = A_COL_LO;
            [8'h10:8'h17]:   act = A_COL_HI;
            default:         act = A_NONE;
          endcase
        end
        ARG1: begin
          case (tgt)
            T_CONTRAST: act = A_CONTRAST;
            T_MODE:     act = A_MODE;
            T_COL:      act = A_COL_START;
            T_PAGE:     act = A_PAGE_START;
            default:    act = A_NONE;
          endcase
        end
        default: begin
          case (tgt)
            T_COL:   act = A_COL_END;
            T_PAGE:  act = A_PAGE_END;
            default: act = A_NONE;
          endcase
        end
      endcase
    end
  end

  // p1: registered strobes and decoder state, visible in E+1
  always_ff @(posedge clk) begin
    if (hold) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_wdata   <= '0;
      cmd_strobe <= 1'b0;
      cmd_byte   <= '0;
      disp_on    <= 1'b0;
      contrast   <= 8'h7F;
      addr_mode  <= 2'b10;
      col        <= '0;
      page       <= '0;
      col_start  <= '0;
      col_end    <= CW'(COLS - 1);
      page_start <= '0;
      page_end   <= PW'(PAGES - 1);
    end else begin
      fb_we      <= (act == A_DATA);
      cmd_strobe <= cmd_vld_p0;
      if (cmd_vld_p0) cmd_byte <= byte_p0;
      case (act)
        A_DISP_OFF:   disp_on <= 1'b0;
        A_DISP_ON:    disp_on <= 1'b1;
        A_CONTRAST:   contrast <= byte_p0;
        A_MODE:       if (byte_p0[1:0] != 2'b11) addr_mode <= byte_p0[1:0];
        A_COL_START:  begin col_start <= byte_p0[CW-1:0]; col <= byte_p0[CW-1:0]; end
        A_COL_END:    col_end <= byte_p0[CW-1:0];
        A_PAGE_START: begin page_start <= byte_p0[PW-1:0]; page <= byte_p0[PW-1:0]; end
        A_PAGE_END:   page_end <= byte_p0[PW-1:0];
        A_PAGE:       page <= byte_p0[PW-1:0];
        A_COL_LO:     col <= {col[CW-1:4], byte_p0[3:0]};
        A_COL_HI:     col <= {byte_p0[2:0], col[3:0]};
        A_DATA: begin
          fb_addr  <= addr_of(page, col);
          fb_wdata <= byte_p0;
          case (addr_mode)
            2'b00: begin
              if (col == col_end) begin
                col  <= col_start;
                page <= (page == page_end) ? page_start : page_inc(page);
              end else begin
                col <= col_inc(col);
              end
            end
            2'b01: begin
              if (page == page_end) begin
                page <= page_start;
                col  <= (col == col_end) ? col_start : col_inc(col);
              end else begin
                page <= page_inc(page);
              end
            end
            default: col <= col_inc(col);
          endcase
        end
        default: ;
      endcase
    end
  end

`ifdef OLED_SINK_FB_EN
  logic [7:0] fb_mem [COLS*PAGES];

  // Frame buffer survives both resets; read port is registered
  always_ff @(posedge clk) begin
    if (fb_we) fb_mem[fb_addr] <= fb_wdata;
    rd_data <= fb_mem[rd_addr];
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
  assign rd_data        = '0;
`endif

endmodule

// File: doc/oled_spi_sink.md
Name: oled_spi_sink

Overview:
- Responder end of the 4-wire OLED serial link (csn, rst, dc, sclk, sdin) driven by the team's OLED12832 controller.
- Behavioural/synthesizable model of an SSD1306-class 128x32 panel's serial front end:
  - samples the link with the system clock and assembles bytes;
  - decodes a command subset;
  - turns data bytes into frame-buffer writes with panel-accurate address auto-increment.
- Used as the bench-side sink for controller verification and as an on-FPGA loopback checker.

Parameters:
- COLS, 128, columns per page.
- PAGES, 4, 8-row pages.
- SYNC_STAGES, 2, synchronizer flops on every link input (min 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- oled_csn  in  1  chip select, active low.
- oled_rst  in  1  panel reset, active low.
- oled_dcn  in  1  0 = command byte, 1 = data byte.
- oled_clk  in  1  serial clock; data sampled on its rising edge.
- oled_dat  in  1  serial data, MSB first.
- fb_we  out  1  one-cycle frame-buffer write strobe.
- fb_addr  out  9  page*COLS+col.
- fb_wdata  out  8  data byte.
- cmd_strobe  out  1  one-cycle pulse per completed command byte (opcode or argument).
- cmd_byte  out  8  last command byte.
- disp_on  out  1  display on flag.
- contrast  out  8  contrast register.
- addr_mode  out  2  00 horizontal, 01 vertical, 10 page.
- rd_addr  in  9  frame-buffer read address.
- rd_data  out  8  frame-buffer read data.

Behaviour:
- Input sync and edge detect:
  - All five link inputs pass through SYNC_STAGES flops.
  - sclk rising edge is detected with one further flop; edge-detect cycle = E.
  - Master sclk high and low phases must each be >= SYNC_STAGES+1 clk periods.
- Shifter:
  - While synced csn = 0, each sclk rise shifts sdin into an 8-bit register, MSB first, and increments a 3-bit count.
  - On the 8th bit, dc is sampled in the same cycle and the byte completes.
  - Outputs for a completed byte (fb_we, cmd_strobe) assert in cycle E+1 for exactly one cycle.
  - csn high clears the bit count and discards any partial byte. Decoder state persists across csn deassertion.
- Panel reset: synced oled_rst = 0 holds all decoder state at reset values (same as rst). Bytes received during that time are ignored.
- Decoder FSM states:
  - IDLE: command byte is decoded as follows.
    - AE/AF: disp_on = 0/1.
    - 81: go to ARG1, target contrast.
    - 20: go to ARG1, target mode; addr_mode = arg[1:0], value 11 ignored.
    - 21: go to ARG1 then ARG2; col_start, col_end = arg[6:0]; col = col_start.
    - 22: go to ARG1 then ARG2; page_start, page_end = arg masked to PAGES range; page = page_start.
    - B0-B3: page = low bits.
    - 00-0F: col[3:0] = nibble.
    - 10-17: col[6:4] = nibble.
    - A8, D3, D5, D9, DA, DB, 8D: consume 1 argument, no effect.
    - Any other byte: no effect.
  - ARG1/ARG2: the next command byte is an argument even if it looks like an opcode.
  - A data byte arriving in ARG1/ARG2 aborts to IDLE and is then processed as data.
- Data byte handling: fb_we = 1, fb_addr = page*COLS+col, fb_wdata = byte, then advance:
  - Horizontal: if col == col_end, col = col_start and page advances (page_end wraps to page_start); else col+1.
  - Vertical: if page == page_end, page = page_start and col advances (col_end wraps to col_start); else page+1.
  - Page: col+1; COLS-1 wraps to 0; page unchanged.
- Reset values:
  - fb_we, cmd_strobe = 0; fb_addr, fb_wdata, cmd_byte = 0.
  - disp_on = 0; contrast = 0x7F; addr_mode = 10.
  - col = page = 0; col_start = 0; col_end = COLS-1; page_start = 0; page_end = PAGES-1.
  - FSM = IDLE; bit count = 0.
- rst and panel reset do not clear frame-buffer contents.

Optional Feature:
- OLED_SINK_FB_EN defined:
  - Internal COLS*PAGES x 8 RAM written by fb_we.
  - rd_data = RAM[rd_addr], registered, 1-cycle latency.
- Undefined: no RAM; rd_data tied to 0; rd_addr unused.

Test Plan:
- rst, then command AF -> cmd_strobe pulses once with cmd_byte = AF; disp_on = 1 at E+1.
- Commands 81, AE -> contrast = AE; disp_on unchanged (AE consumed as argument).
- Page mode: commands B2, 05, 13, then data A5, 3C -> fb_we writes addr 309 = A5 and addr 310 = 3C.
- Horizontal: commands 20,00 / 21,7E,7F / 22,00,03, then five data bytes -> fb_addr sequence 126, 127, 254, 255, 382.
- csn raised after 5 bits, then full command AF -> no strobe for the partial byte; exactly one strobe for AF; disp_on = 1.
- oled_rst pulsed low mid-stream -> contrast = 7F, addr_mode = 10, FSM in IDLE; with OLED_SINK_FB_EN, rd_addr = 309 returns A5 one cycle later.
